reg_rename_file: RTL
====================

REG_RENAME_FILE -- requirements
Module: reg_rename_file

Interface
REQ-001 Parameter NREGS SHALL be: NREGS, 8, architectural register count (power of 2, >=2).
REQ-002 Parameter DATA_W SHALL be: DATA_W, 16, register data width.
REQ-003 Parameter ROB_W SHALL be: ROB_W, 6, ROB tag width.
REQ-004 Parameter NRD SHALL be: NRD, 8, read port count.
REQ-005 Parameter NREN SHALL be: NREN, 4, rename port count.
REQ-006 Parameter NWB SHALL be: NWB, 3, writeback port count.
REQ-007 Derived widths SHALL be AW=clog2(NREGS) and RW=DATA_W+1+ROB_W. Port i of any packed bus SHALL occupy [i*W +: W].
REQ-008 The block SHALL have one clock, clk, and a reset, rst, which is synchronous and active-high.
REQ-009 Port list:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- raddr  input  NRD*AW  read addresses.
- rdata  output  NRD*RW  per port {data, busy, tag}.
- ren_en  input  NREN  rename valid.
- ren_addr  input  NREN*AW  rename destination register.
- ren_tag  input  NREN*ROB_W  ROB tag being allocated.
- wb_en  input  NWB  writeback valid.
- wb_addr  input  NWB*AW  writeback register.
- wb_data  input  NWB*DATA_W  writeback data.
- wb_tag  input  NWB*ROB_W  ROB tag of the producer.
- flush  input  1  pipeline flush.
- trap_read  output  DATA_W  register 0 data.

Function
REQ-010 Each raddr SHALL be registered on every clk edge. rdata SHALL be driven combinationally from the registered address and the current array, giving 1-cycle latency. rdata SHALL reflect all writes made at that same edge.
REQ-011 When ren_en[i] is high, the block SHALL set busy[ren_addr[i]]=1 and tag[ren_addr[i]]=ren_tag[i].
- Same-register conflicts between rename ports: the highest index wins (issue places the youngest instruction highest).
REQ-012 When wb_en[j] is high, the block SHALL write data[wb_addr[j]]=wb_data[j] unconditionally.
- Same-register conflicts between writeback ports: the highest index wins the data.
REQ-013 busy[r] SHALL clear only when all of the following hold:
- some wb_en[j] targets r with wb_tag[j]==tag[r];
- busy[r]==1;
- no rename to r occurs that cycle.
REQ-014 Rename and writeback to the same register in the same cycle SHALL write the data and leave busy=1 with the new tag.
REQ-015 flush SHALL clear every busy bit at the edge, overriding same-cycle renames; tags SHALL remain unchanged and writeback data SHALL still be written.
REQ-016 trap_read SHALL equal data[0] combinationally.
REQ-017 Tag values SHALL be stored as given, with no wrap or age logic; tag comparison SHALL be exact equality.

Reset
REQ-018 With rst high at an edge, the block SHALL zero all data, busy, tag and registered read addresses, overriding rename, writeback and flush. rdata and trap_read SHALL then read 0.

Configuration
REQ-019 When RRF_WB_BYPASS_EN is defined, a read port whose registered address matches an active writeback SHALL present that cycle's wb_data (highest index) combinationally, with busy shown as 0 when REQ-013 holds; the tag field SHALL be unchanged.
REQ-020 When RRF_WB_BYPASS_EN is undefined, rdata SHALL show stored state only.

Structure
REQ-021 Package rrf_pkg SHALL hold the default parameters, the RW computation and the rdata field offset constants (TAG_LSB=0, BUSY_BIT=ROB_W, DATA_LSB=ROB_W+1).
REQ-022 Sub-module rrf_prio_sel SHALL resolve the per-register highest-index valid port and its payload. It SHALL be instantiated once for renames and once for writebacks.

Verification
REQ-023 Reset then raddr0=3: one cycle later rdata0 SHALL equal 0.
REQ-024 Rename r2 with tag 5, then wb r2 with tag 5 and data 0xBEEF: rdata for r2 SHALL go {0,1,5}, then {0xBEEF,0,5}.
REQ-025 Renames on ports 0 and 3 to r4 with tags 7 and 9, then wb r4 with tag 7: tag SHALL read 9, busy SHALL stay 1, and data SHALL update.
REQ-026 Same-cycle rename r1 with tag 12 and wb r1 with tag 12 and data 0x1234: busy SHALL be 1, tag 12, data 0x1234.
REQ-027 Busy r1, r2 and r6, then flush with rename r3 in the same cycle: all busy bits SHALL read 0, and the tag of r3 SHALL be unchanged.
REQ-028 With the bypass macro defined, wb r5 with data 0x00AA in the same cycle that read port 1 has registered r5: rdata1 data SHALL be 0x00AA that cycle. With the macro undefined, it SHALL show the old value until the next edge.

Source files
------------

// File: rtl/rrf_pkg.sv
// rtl/rrf_pkg.sv - default parameters, entry width and rdata field offsets for reg_rename_file
package rrf_pkg;

  localparam int DEF_NREGS  = 8;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ROB_W  = 6;
  localparam int DEF_NRD    = 8;
  localparam int DEF_NREN   = 4;
  localparam int DEF_NWB    = 3;

  // Each read word is {data, busy, tag}, tag in the low bits.
  localparam int TAG_LSB  = 0;
  localparam int BUSY_BIT = DEF_ROB_W;
  localparam int DATA_LSB = DEF_ROB_W + 1;

  function automatic int calc_rw(input int data_w, input int rob_w);
    return data_w + 1 + rob_w;
  endfunction

  function automatic int busy_bit(input int rob_w);
    return rob_w;
  endfunction

  function automatic int data_lsb(input int rob_w);
    return rob_w + 1;
  endfunction

endpackage

// File: rtl/rrf_prio_sel.sv
// rtl/rrf_prio_sel.sv - per-register highest-index valid port select with payload
module rrf_prio_sel #(
  parameter int NPORT = 4,
  parameter int NREGS = 8,
  parameter int AW    = 3,
  parameter int PW    = 6
) (
  input  logic [NPORT-1:0]    i_en,
  input  logic [NPORT*AW-1:0] i_addr,
  input  logic [NPORT*PW-1:0] i_payload,
  output logic [NREGS-1:0]    o_hit,
  output logic [NREGS*PW-1:0] o_payload
);

  // Ascending scan: a later (higher) port overwrites an earlier one.
  always_comb begin
    o_hit     = '0;
    o_payload = '0;
    for (int p = 0; p < NPORT; p++) begin
      if (i_en[p]) begin
        o_hit[i_addr[p*AW +: AW]] = 1'b1;
        o_payload[int'(i_addr[p*AW +: AW])*PW +: PW] = i_payload[p*PW +: PW];
      end
    end
  end

endmodule

// File: rtl/reg_rename_file.sv
// rtl/reg_rename_file.sv - register file with busy/tag rename state; RRF_WB_BYPASS_EN adds writeback bypass
module reg_rename_file
  import rrf_pkg::*;
#(
  parameter int NREGS  = DEF_NREGS,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ROB_W  = DEF_ROB_W,
  parameter int NRD    = DEF_NRD,
  parameter int NREN   = DEF_NREN,
  parameter int NWB    = DEF_NWB,
  localparam int AW    = $clog2(NREGS),
  localparam int RW    = calc_rw(DATA_W, ROB_W)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*AW-1:0]     raddr,
  output logic [NRD*RW-1:0]     rdata,
  input  logic [NREN-1:0]       ren_en,
  input  logic [NREN*AW-1:0]    ren_addr,
  input  logic [NREN*ROB_W-1:0] ren_tag,
  input  logic [NWB-1:0]        wb_en,
  input  logic [NWB*AW-1:0]     wb_addr,
  input  logic [NWB*DATA_W-1:0] wb_data,
  input  logic [NWB*ROB_W-1:0]  wb_tag,
  input  logic                  flush,
  output logic [DATA_W-1:0]     trap_read
);

  localparam int L_BUSY = busy_bit(ROB_W);
  localparam int L_DATA = data_lsb(ROB_W);

  logic [DATA_W-1:0] r_data  [NREGS];
  logic [ROB_W-1:0]  r_tag   [NREGS];
  logic [NREGS-1:0]  r_busy;
  logic [AW-1:0]     r_raddr [NRD];

  logic [NREGS-1:0]        w_ren_hit;
  logic [NREGS*ROB_W-1:0]  w_ren_tag;
  logic [NREGS-1:0]        w_wb_hit;
  logic [NREGS*DATA_W-1:0] w_wb_data;
  logic [NREGS-1:0]        w_tag_match;
  logic [NREGS-1:0]        w_clr;

  rrf_prio_sel #(.NPORT(NREN), .NREGS(NREGS), .AW(AW), .PW(ROB_W)) u_ren_sel (
    .i_en(ren_en), .i_addr(ren_addr), .i_payload(ren_tag),
    .o_hit(w_ren_hit), .o_payload(w_ren_tag)
  );

  rrf_prio_sel #(.NPORT(NWB), .NREGS(NREGS), .AW(AW), .PW(DATA_W)) u_wb_sel (
    .i_en(wb_en), .i_addr(wb_addr), .i_payload(wb_data),
    .o_hit(w_wb_hit), .o_payload(w_wb_data)
  );

  // Any writeback port carrying the stored tag may retire the producer, not only the data winner.
  always_comb begin
    w_tag_match = '0;
    for (int j = 0; j < NWB; j++) begin
      if (wb_en[j] && (wb_tag[j*ROB_W +: ROB_W] == r_tag[wb_addr[j*AW +: AW]]))
        w_tag_match[wb_addr[j*AW +: AW]] = 1'b1;
    end
  end

  assign w_clr = r_busy & w_tag_match & ~w_ren_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        r_data[r] <= '0;
        r_tag[r]  <= '0;
      end
      for (int i = 0; i < NRD; i++) r_raddr[i] <= '0;
      r_busy <= '0;
    end else begin
      for (int i = 0; i < NRD; i++) r_raddr[i] <= raddr[i*AW +: AW];
      for (int r = 0; r < NREGS; r++) begin
        if (w_wb_hit[r]) r_data[r] <= w_wb_data[r*DATA_W +: DATA_W];
        if (w_ren_hit[r] && !flush) r_tag[r] <= w_ren_tag[r*ROB_W +: ROB_W];
      end
      r_busy <= flush ? '0 : ((r_busy | w_ren_hit) & ~w_clr);
    end
  end

  always_comb begin
    logic [AW-1:0]     w_a;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_rd_busy;
    rdata     = '0;
    w_a       = '0;
    w_rd_data = '0;
    w_rd_busy = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      w_a       = r_raddr[i];
      w_rd_data = r_data[w_a];
      w_rd_busy = r_busy[w_a];
`ifdef RRF_WB_BYPASS_EN
      if (w_wb_hit[w_a]) begin
        w_rd_data = w_wb_data[int'(w_a)*DATA_W +: DATA_W];
        w_rd_busy = r_busy[w_a] & ~w_clr[w_a];
      end
`endif
      rdata[i*RW + TAG_LSB +: ROB_W]  = r_tag[w_a];
      rdata[i*RW + L_BUSY]            = w_rd_busy;
      rdata[i*RW + L_DATA +: DATA_W]  = w_rd_data;
    end
  end

  assign trap_read = r_data[0];

endmodule
